// File: rtl/centipede_bus_pkg.sv
// Shared types and default region table for the Centipede bus region controller.
// Region order sets decode priority: the lowest index wins on overlap.
package centipede_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    STROBE = 2'd2
  } state_t;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_N_REGIONS   = 4;
  localparam int DEF_WAIT_W      = 3;
  localparam int DEF_WDOG_W      = 4;

  localparam int RGN_RAM0     = 0;
  localparam int RGN_POKEY    = 1;
  localparam int RGN_WATCHDOG = 2;
  localparam int RGN_ROM      = 3;

  localparam int DEF_WDOG_REGION = RGN_WATCHDOG;

  // WATCHDOG sits inside the ROM window, so it must keep a lower index than ROM.
  localparam logic [DEF_N_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {16'h2000, 16'h2480, 16'h1000, 16'h0000};
  localparam logic [DEF_N_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_MASK =
    {16'hE000, 16'hFF80, 16'hFC00, 16'hFC00};
  localparam logic [DEF_N_REGIONS*DEF_WAIT_W-1:0] DEF_REGION_WAIT =
    {3'd1, 3'd0, 3'd2, 3'd0};

endpackage

// File: rtl/bus_region_controller_if.sv
// CPU-side bus bundle: access request in, chip selects, strobes and status out.
interface bus_region_controller_if
  import centipede_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int N_REGIONS = DEF_N_REGIONS
);

  logic                 cpu_req;
  logic [ADDR_W-1:0]    cpu_addr;
  logic                 cpu_rw;
  logic                 wdog_tick;
  logic [N_REGIONS-1:0] cs_n;
  logic                 rd_n;
  logic                 wr_n;
  logic                 cpu_rdy;
  logic                 busy;
  logic                 miss;
  logic                 wdog_expired;

  modport master (
    output cpu_req, cpu_addr, cpu_rw, wdog_tick,
    input  cs_n, rd_n, wr_n, cpu_rdy, busy, miss, wdog_expired
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_rw, wdog_tick,
    output cs_n, rd_n, wr_n, cpu_rdy, busy, miss, wdog_expired
  );

endinterface

// File: rtl/bus_region_controller_watchdog.sv
// Watchdog counter: counts time-base ticks, cleared by a watchdog write,
// pulses expired_o for one cycle when a tick wraps the count.
module watchdog_timer #(
  parameter int WDOG_W = 4
) (
  input  logic clk,
  input  logic rst_l,
  input  logic tick_i,
  input  logic clear_i,
  output logic expired_o
);

  logic [WDOG_W-1:0] count_q, count_d;
  logic              expired_q, expired_d;

  // A clear in the same cycle as a tick suppresses both the increment and the expiry.
  always_comb begin
    count_d   = count_q;
    expired_d = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d   = count_q + WDOG_W'(1);
      expired_d = &count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/bus_region_controller.sv
// Registered region decoder: one-cold chip selects, per-region wait states,
// single-cycle read/write strobe, plus the watchdog clear path.
module bus_region_controller
  import centipede_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int N_REGIONS   = DEF_N_REGIONS,
  parameter int WAIT_W      = DEF_WAIT_W,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [N_REGIONS*WAIT_W-1:0] REGION_WAIT = DEF_REGION_WAIT,
  parameter int WDOG_REGION = DEF_WDOG_REGION,
  parameter int WDOG_W      = DEF_WDOG_W
) (
  input logic                   clk,
  input logic                   rst_l,
  bus_region_controller_if.slave bus
);

  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  logic [N_REGIONS-1:0] hit;
  logic [IDX_W-1:0]     hit_idx;
  logic [WAIT_W-1:0]    wait_tbl [N_REGIONS];

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     region_q, region_d;
  logic                 rw_q, rw_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [N_REGIONS-1:0] cs_n_q, cs_n_d;
  logic                 rd_n_q, rd_n_d;
  logic                 wr_n_q, wr_n_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 miss_q, miss_d;
  logic                 wdog_clear;
  logic                 wdog_expired;

  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_decode
      assign hit[gi] = (bus.cpu_addr & REGION_MASK[gi*ADDR_W +: ADDR_W])
                       == REGION_BASE[gi*ADDR_W +: ADDR_W];
      assign wait_tbl[gi] = REGION_WAIT[gi*WAIT_W +: WAIT_W];
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    miss_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (|hit) begin
            region_d = hit_idx;
            rw_d     = bus.cpu_rw;
            cnt_d    = wait_tbl[hit_idx];
            state_d  = ACCESS;
          end else begin
            miss_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) cnt_d = cnt_q - WAIT_W'(1);
        else             state_d = STROBE;
      end
      STROBE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered, glitch-free.
    cs_n_d = '1;
    if (state_d != IDLE) cs_n_d = ~(N_REGIONS'(1) << region_d);
    busy_d = (state_d != IDLE);
    rdy_d  = (state_d != ACCESS);
    rd_n_d = !((state_d == STROBE) && rw_d);
    wr_n_d = !((state_d == STROBE) && !rw_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      region_q <= '0;
      rw_q     <= 1'b1;
      cnt_q    <= '0;
      cs_n_q   <= '1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      miss_q   <= miss_d;
    end
  end

  assign wdog_clear = (state_q == STROBE) && !rw_q && (region_q == IDX_W'(WDOG_REGION));

  watchdog_timer #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk       (clk),
    .rst_l     (rst_l),
    .tick_i    (bus.wdog_tick),
    .clear_i   (wdog_clear),
    .expired_o (wdog_expired)
  );

  assign bus.cs_n         = cs_n_q;
  assign bus.rd_n         = rd_n_q;
  assign bus.wr_n         = wr_n_q;
  assign bus.cpu_rdy      = rdy_q;
  assign bus.busy         = busy_q;
  assign bus.miss         = miss_q;
  assign bus.wdog_expired = wdog_expired;

endmodule

// File: tb/tb_bus_region_controller.sv
// Directed bench for bus_region_controller: reset, decode priority, wait states,
// miss pulse and watchdog behaviour, checked on the falling edge.
module tb_bus_region_controller;
  import centipede_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_l;
  int   n_vec = 0;
  int   n_err = 0;

  bus_region_controller_if #(.ADDR_W(16), .N_REGIONS(4)) bus ();

  bus_region_controller dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected pattern: {cs_n[3:0], rd_n, wr_n, cpu_rdy, busy, miss, wdog_expired}
  localparam logic [9:0] P_IDLE = {4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [9:0] P_MISS = {4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  function automatic logic [9:0] p_access(input logic [3:0] cs);
    return {cs, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [9:0] p_strobe(input logic [3:0] cs, input logic rd);
    return {cs, !rd, rd, 1'b1, 1'b1, 1'b0, 1'b0};
  endfunction

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic chk_bus(input string tag, input logic [9:0] exp_v);
    logic [9:0] obs;
    obs = {bus.cs_n, bus.rd_n, bus.wr_n, bus.cpu_rdy, bus.busy, bus.miss, bus.wdog_expired};
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
    $display("vec %0d %s bus=%b", n_vec, tag, obs);
  endtask

  task automatic chk_exp(input string tag, input logic exp_v);
    n_vec++;
    assert (bus.wdog_expired === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.wdog_expired, exp_v);
    end
    $display("vec %0d %s wdog_expired=%b", n_vec, tag, bus.wdog_expired);
  endtask

  // n ticks on consecutive cycles; pulse expected only after tick number pulse_at.
  task automatic ticks(input string tag, input int n, input int pulse_at);
    for (int k = 1; k <= n; k++) begin
      bus.wdog_tick = 1'b1;
      adv();
      chk_exp(tag, k == pulse_at);
    end
    bus.wdog_tick = 1'b0;
  endtask

  task automatic access(input string tag, input logic [15:0] addr, input logic rw,
                        input logic [3:0] cs, input int waits);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_rw   = rw;
    adv();
    bus.cpu_req = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      chk_bus({tag, "_access"}, p_access(cs));
      adv();
    end
    chk_bus({tag, "_strobe"}, p_strobe(cs, rw));
    adv();
    chk_bus({tag, "_release"}, P_IDLE);
  endtask

  initial begin
    rst_l         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_rw    = 1'b1;
    bus.wdog_tick = 1'b0;
    adv();
    adv();
    chk_bus("reset_state", P_IDLE);
    rst_l = 1'b1;
    adv();
    chk_bus("post_reset_idle", P_IDLE);

    // Reset during ACCESS of a POKEY read: abandoned, no strobe afterwards.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h1004;
    bus.cpu_rw   = 1'b1;
    adv();
    bus.cpu_req = 1'b0;
    chk_bus("rst_mid_access", p_access(4'b1101));
    rst_l = 1'b0;
    adv();
    chk_bus("rst_mid_abandon", P_IDLE);
    rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      adv();
      chk_bus("rst_mid_no_strobe", P_IDLE);
    end

    // RAM read, no wait states.
    access("ram_rd_0123", 16'h0123, 1'b1, 4'b1110, 0);

    // POKEY write, two wait states, second request during ACCESS ignored.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h1000;
    bus.cpu_rw   = 1'b0;
    adv();
    bus.cpu_req = 1'b0;
    chk_bus("pokey_wr_t1", p_access(4'b1101));
    adv();
    chk_bus("pokey_wr_t2", p_access(4'b1101));
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h8000;
    bus.cpu_rw   = 1'b1;
    adv();
    bus.cpu_req = 1'b0;
    chk_bus("pokey_wr_t3_ignored", p_access(4'b1101));
    adv();
    chk_bus("pokey_wr_t4_strobe", p_strobe(4'b1101, 1'b0));
    adv();
    chk_bus("pokey_wr_t5_release", P_IDLE);
    adv();
    chk_bus("pokey_wr_t6_no_retry", P_IDLE);

    // Miss: unmapped address.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h8000;
    bus.cpu_rw   = 1'b1;
    adv();
    bus.cpu_req = 1'b0;
    chk_bus("miss_8000", P_MISS);
    adv();
    chk_bus("miss_clear", P_IDLE);

    // ROM read (overlaps nothing lower), one wait state.
    access("rom_rd_3000", 16'h3000, 1'b1, 4'b0111, 1);

    // Watchdog free-running: exactly one pulse on the 16th tick.
    ticks("wdog_16", 16, 16);
    adv();
    chk_exp("wdog_after_wrap", 1'b0);

    // A watchdog-region read must not clear: 5 + 11 ticks expires on the 11th.
    ticks("wdog_pre_rd", 5, 0);
    access("wdog_rd_2481", 16'h2481, 1'b1, 4'b1011, 0);
    ticks("wdog_after_rd", 11, 11);

    // A watchdog-region write wins over ROM and clears: next pulse needs 16 ticks.
    ticks("wdog_pre_wr", 5, 0);
    access("wdog_wr_2480", 16'h2480, 1'b0, 4'b1011, 0);
    ticks("wdog_after_wr", 16, 16);

    // Clear coincident with the 16th tick: no pulse, count restarts at 0.
    ticks("wdog_pre_coinc", 15, 0);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h2480;
    bus.cpu_rw   = 1'b0;
    adv();
    bus.cpu_req = 1'b0;
    chk_bus("coinc_access", p_access(4'b1011));
    adv();
    chk_bus("coinc_strobe", p_strobe(4'b1011, 1'b0));
    bus.wdog_tick = 1'b1;
    adv();
    bus.wdog_tick = 1'b0;
    chk_bus("coinc_no_pulse", P_IDLE);
    ticks("wdog_after_coinc", 16, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
